// File: rtl/conv_och_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_och_sequencer
// Brief    : Layer control for one convolution layer: bias DMA load, then
//            LANES-wide output-channel groups with per-lane bias fetch.
// Revision : 1.0 - initial release
// ============================================================================
module conv_och_sequencer #(
    parameter int BIAS_BITS = 16,
    parameter int CH_BITS   = 9,
    parameter int LANES     = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ap_start,
    input  logic                       ap_abort,
    input  logic [CH_BITS-1:0]         cfg_out_ch,
    input  logic                       cfg_skip_bias_load,
    output logic                       ap_idle,
    output logic                       ap_done,
    output logic                       bias_load_start,
    output logic                       dma_bias,
    input  logic                       bias_load_done,
    output logic                       bias_request,
    output logic [CH_BITS-1:0]         bias_addr,
    input  logic [BIAS_BITS-1:0]       bias_o,
    input  logic                       bias_vld_o,
    output logic [LANES*BIAS_BITS-1:0] input_bias,
    output logic [LANES-1:0]           lane_en,
    output logic [CH_BITS-1:0]         och_base,
    output logic                       group_last,
    output logic                       calc_start,
    input  logic                       calc_done
);

    localparam int               c_lw    = $clog2(LANES + 1);
    localparam logic [CH_BITS:0] c_lanes = (CH_BITS + 1)'(LANES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BIAS_LOAD  = 3'd1,
        S_GROUP_INIT = 3'd2,
        S_BIAS_FETCH = 3'd3,
        S_CALC_WAIT  = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [CH_BITS-1:0]         r_out_ch;
    logic [CH_BITS:0]           r_och_base;
    logic [c_lw-1:0]            r_lane;
    logic [c_lw-1:0]            r_n;
    logic                       r_pending;

    logic [CH_BITS-1:0]         w_out_ch_nxt;
    logic [CH_BITS:0]           w_och_base_nxt;
    logic [c_lw-1:0]            w_lane_nxt;
    logic [c_lw-1:0]            w_n_nxt;
    logic                       w_pending_nxt;
    logic                       w_idle_nxt;
    logic                       w_done_nxt;
    logic                       w_load_nxt;
    logic                       w_req_nxt;
    logic [CH_BITS-1:0]         w_addr_nxt;
    logic [LANES*BIAS_BITS-1:0] w_bias_nxt;
    logic [LANES-1:0]           w_lane_en_nxt;
    logic                       w_last_nxt;
    logic                       w_calc_start_nxt;

    logic [CH_BITS:0]           w_remaining;
    logic [c_lw-1:0]            w_n_grp;
    logic [LANES-1:0]           w_mask;
    logic [c_lw-1:0]            w_lane_inc;
    logic [CH_BITS-1:0]         w_addr_inc;

    // Group arithmetic runs one bit wider than the channel count so the
    // remaining-channel difference can never wrap.
    assign w_remaining = {1'b0, r_out_ch} - r_och_base;
    assign w_n_grp     = (w_remaining < c_lanes) ? w_remaining[c_lw-1:0] : c_lw'(LANES);
    assign w_lane_inc  = r_lane + c_lw'(1);
    // Addresses stay below out_ch, so the channel-wide sum cannot overflow.
    assign w_addr_inc  = r_och_base[CH_BITS-1:0] + CH_BITS'(w_lane_inc);
    assign och_base    = r_och_base[CH_BITS-1:0];

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            w_mask[k] = (c_lw'(k) < w_n_grp);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_out_ch        <= '0;
            r_och_base      <= '0;
            r_lane          <= '0;
            r_n             <= '0;
            r_pending       <= 1'b0;
            ap_idle         <= 1'b1;
            ap_done         <= 1'b0;
            bias_load_start <= 1'b0;
            dma_bias        <= 1'b0;
            bias_request    <= 1'b0;
            bias_addr       <= '0;
            input_bias      <= '0;
            lane_en         <= '0;
            group_last      <= 1'b0;
            calc_start      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_out_ch        <= w_out_ch_nxt;
            r_och_base      <= w_och_base_nxt;
            r_lane          <= w_lane_nxt;
            r_n             <= w_n_nxt;
            r_pending       <= w_pending_nxt;
            ap_idle         <= w_idle_nxt;
            ap_done         <= w_done_nxt;
            bias_load_start <= w_load_nxt;
            dma_bias        <= w_load_nxt;
            bias_request    <= w_req_nxt;
            bias_addr       <= w_addr_nxt;
            input_bias      <= w_bias_nxt;
            lane_en         <= w_lane_en_nxt;
            group_last      <= w_last_nxt;
            calc_start      <= w_calc_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_out_ch_nxt     = r_out_ch;
        w_och_base_nxt   = r_och_base;
        w_lane_nxt       = r_lane;
        w_n_nxt          = r_n;
        w_pending_nxt    = r_pending;
        w_done_nxt       = 1'b0;
        w_load_nxt       = bias_load_start;
        w_req_nxt        = 1'b0;
        w_addr_nxt       = bias_addr;
        w_bias_nxt       = input_bias;
        w_lane_en_nxt    = lane_en;
        w_last_nxt       = group_last;
        w_calc_start_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_out_ch_nxt   = cfg_out_ch;
                    w_och_base_nxt = '0;
                    if (cfg_out_ch == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (cfg_skip_bias_load) begin
                        w_state_nxt = S_GROUP_INIT;
                    end else begin
                        w_state_nxt = S_BIAS_LOAD;
                        w_load_nxt  = 1'b1;
                    end
                end
            end
            S_BIAS_LOAD: begin
                if (bias_load_done) begin
                    w_load_nxt  = 1'b0;
                    w_state_nxt = S_GROUP_INIT;
                end
            end
            S_GROUP_INIT: begin
                // The first request of the group leaves together with the
                // new lane mask so it appears on the cycle after GROUP_INIT.
                w_n_nxt       = w_n_grp;
                w_lane_en_nxt = w_mask;
                w_bias_nxt    = '0;
                w_last_nxt    = (w_remaining <= c_lanes);
                w_lane_nxt    = '0;
                w_req_nxt     = 1'b1;
                w_addr_nxt    = r_och_base[CH_BITS-1:0];
                w_pending_nxt = 1'b1;
                w_state_nxt   = S_BIAS_FETCH;
            end
            S_BIAS_FETCH: begin
                if (r_pending && bias_vld_o) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (r_lane == c_lw'(k)) begin
                            w_bias_nxt[k*BIAS_BITS +: BIAS_BITS] = bias_o;
                        end
                    end
                    w_lane_nxt = w_lane_inc;
                    if (w_lane_inc < r_n) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = w_addr_inc;
                    end else begin
                        w_pending_nxt    = 1'b0;
                        w_calc_start_nxt = 1'b1;
                        w_state_nxt      = S_CALC_WAIT;
                    end
                end
            end
            S_CALC_WAIT: begin
                // A done seen alongside our own start pulse is stale.
                if (calc_done && !calc_start) begin
                    if (group_last) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_och_base_nxt = r_och_base + c_lanes;
                        w_state_nxt    = S_GROUP_INIT;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (ap_abort) begin
            w_state_nxt      = S_IDLE;
            w_out_ch_nxt     = '0;
            w_och_base_nxt   = '0;
            w_lane_nxt       = '0;
            w_n_nxt          = '0;
            w_pending_nxt    = 1'b0;
            w_done_nxt       = 1'b0;
            w_load_nxt       = 1'b0;
            w_req_nxt        = 1'b0;
            w_addr_nxt       = '0;
            w_bias_nxt       = '0;
            w_lane_en_nxt    = '0;
            w_last_nxt       = 1'b0;
            w_calc_start_nxt = 1'b0;
        end

        w_idle_nxt = (w_state_nxt == S_IDLE);
    end

endmodule
`default_nettype wire
